// File: rtl/dct_seq_ctrl.sv
// Collects 8 samples, fires the DCT and streams the 8 coefficients one per handshake.
// First coefficient comes DCT_LAT+1 cycles after the 8th sample; s_ready is low outside FILL and m_ready stalls the drain.
module dct_seq_ctrl #(
    parameter int IN_W    = 8,
    parameter int OUT_W   = 19,
    parameter int DCT_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    input  logic signed [IN_W-1:0]  s_data,
    output logic                    s_ready,
    output logic [8*IN_W-1:0]       dct_in,
    output logic                    dct_en,
    output logic                    dct_cs,
    input  logic [8*OUT_W-1:0]      dct_z,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [OUT_W-1:0] m_data,
    output logic [2:0]              m_index,
    output logic                    m_last,
    output logic [15:0]             blk_cnt,
    output logic                    busy
);

    typedef enum logic [1:0] {S_FILL, S_FIRE, S_WAIT, S_DRAIN} state_t;

    localparam logic [3:0] LAT_M1 = 4'(DCT_LAT - 1);

    state_t           state_q, state_d;
    logic [2:0]       fill_cnt_q, fill_cnt_d;
    logic [2:0]       drain_cnt_q, drain_cnt_d;
    logic [3:0]       wait_cnt_q, wait_cnt_d;
    logic [15:0]      blk_cnt_q, blk_cnt_d;
    logic [IN_W-1:0]  smp_q [8];
    logic [IN_W-1:0]  smp_d [8];
    logic [OUT_W-1:0] coef_q [8];
    logic [OUT_W-1:0] coef_d [8];

    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        drain_cnt_d = drain_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        blk_cnt_d   = blk_cnt_q;
        smp_d       = smp_q;
        coef_d      = coef_q;
        s_ready     = 1'b0;
        dct_en      = 1'b0;
        m_valid     = 1'b0;
        case (state_q)
            S_FILL: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    smp_d[fill_cnt_q] = s_data;
                    fill_cnt_d        = fill_cnt_q + 3'd1;
                    if (fill_cnt_q == 3'd7) begin
                        state_d = S_FIRE;
                    end
                end
            end
            S_FIRE: begin
                dct_en     = 1'b1;
                wait_cnt_d = LAT_M1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                // Sample lanes stay untouched here, so the DCT sees a stable block until capture.
                dct_en = 1'b1;
                if (wait_cnt_q == 4'd0) begin
                    for (int k = 0; k < 8; k++) begin
                        coef_d[k] = dct_z[k*OUT_W +: OUT_W];
                    end
                    state_d = S_DRAIN;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            S_DRAIN: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    drain_cnt_d = drain_cnt_q + 3'd1;
                    if (drain_cnt_q == 3'd7) begin
                        blk_cnt_d  = blk_cnt_q + 16'd1;
                        fill_cnt_d = 3'd0;
                        state_d    = S_FILL;
                    end
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FILL;
            fill_cnt_q  <= 3'd0;
            drain_cnt_q <= 3'd0;
            wait_cnt_q  <= 4'd0;
            blk_cnt_q   <= 16'd0;
            for (int k = 0; k < 8; k++) begin
                smp_q[k]  <= '0;
                coef_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            blk_cnt_q   <= blk_cnt_d;
            smp_q       <= smp_d;
            coef_q      <= coef_d;
        end
    end

    always_comb begin
        dct_in = '0;
        for (int k = 0; k < 8; k++) begin
            dct_in[k*IN_W +: IN_W] = smp_q[k];
        end
    end

    assign dct_cs  = dct_en;
    assign m_data  = coef_q[drain_cnt_q];
    assign m_index = drain_cnt_q;
    assign m_last  = (state_q == S_DRAIN) && (drain_cnt_q == 3'd7);
    assign blk_cnt = blk_cnt_q;
    assign busy    = (state_q != S_FILL);

endmodule

// File: doc/dct_seq_ctrl.md
DCT_SEQ_CTRL -- requirements
Module: dct_seq_ctrl

Interface
REQ-001 SHALL have parameter IN_W, default 8, sample width (signed).
REQ-002 SHALL have parameter OUT_W, default 19, coefficient width (signed).
REQ-003 SHALL have parameter DCT_LAT, default 2, cycles from the en/cs pulse to valid DCT outputs; legal range 1..15.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port s_valid  input  1  input sample valid.
REQ-007 SHALL have port s_data  input  IN_W  signed EEG sample.
REQ-008 SHALL have port s_ready  output  1  controller accepts a sample this cycle.
REQ-009 SHALL have port dct_in  output  8*IN_W  buffered block; lane k at bits [k*IN_W +: IN_W] drives DCT input k.
REQ-010 SHALL have ports dct_en and dct_cs  output  1 each  DCT enable and chip select.
REQ-011 SHALL have port dct_z  input  8*OUT_W  DCT coefficients Z0..Z7; lane k at bits [k*OUT_W +: OUT_W].
REQ-012 SHALL have port m_valid  output  1  coefficient valid, toward the RLE stage.
REQ-013 SHALL have port m_ready  input  1  RLE stage accepts the coefficient.
REQ-014 SHALL have port m_data  output  OUT_W  current coefficient.
REQ-015 SHALL have port m_index  output  3  coefficient index, 0..7.
REQ-016 SHALL have port m_last  output  1  high with index 7.
REQ-017 SHALL have port blk_cnt  output  16  count of completed blocks.
REQ-018 SHALL have port busy  output  1  high in any state other than FILL.

Function
REQ-019 SHALL implement the states FILL, FIRE, WAIT and DRAIN.
REQ-020 FILL: s_ready=1; each s_valid&&s_ready stores s_data in lane fill_cnt and increments fill_cnt (3 bits); on the 8th accept (fill_cnt==7), go to FIRE.
REQ-021 FIRE: one cycle with dct_en=dct_cs=1; the wait counter loads DCT_LAT-1; go to WAIT.
REQ-022 WAIT: dct_en=dct_cs=1 held; the counter decrements each cycle; at 0, capture all 8 dct_z lanes into the coefficient register and go to DRAIN.
REQ-023 Capture occurs exactly DCT_LAT cycles after the FIRE cycle.
REQ-024 The dct_in lanes SHALL remain stable from the FIRE cycle through the capture cycle.
REQ-025 DRAIN: m_valid=1; m_data = coefficient lane drain_cnt; m_index = drain_cnt; m_last = (drain_cnt==7).
REQ-026 DRAIN: drain_cnt advances only on m_valid&&m_ready.
REQ-027 DRAIN: m_data, m_index and m_last SHALL hold stable while m_valid&&!m_ready.
REQ-028 The handshake on index 7 SHALL increment blk_cnt and return the block to FILL with fill_cnt=0 on the next cycle.
REQ-029 blk_cnt SHALL wrap from 0xFFFF to 0x0000.
REQ-030 s_ready SHALL be 0 outside FILL; s_valid asserted there is ignored and no sample is stored.
REQ-031 The controller SHALL not drop or duplicate samples or coefficients under any s_valid/m_ready pattern.
REQ-032 Back-to-back operation: full throughput is 8 samples in, then DCT_LAT+1 cycles, then 8 coefficients out; no overlap between blocks.
REQ-033 Arithmetic: the controller passes data only; it performs no truncation or sign change of samples or coefficients.

Reset
REQ-034 On rst=1 at a clock edge, the state SHALL go to FILL and fill_cnt, drain_cnt, the wait counter and blk_cnt SHALL clear to 0.
REQ-035 On reset, the sample and coefficient registers SHALL clear to 0.
REQ-036 On reset, the outputs SHALL be: s_ready=1 from the first cycle after reset, and dct_en=dct_cs=m_valid=m_last=busy=0, m_index=0.
REQ-037 Reset mid-FILL, mid-WAIT or mid-DRAIN SHALL abandon the partial block and leave blk_cnt=0; the first sample after reset lands in lane 0.

Verification
REQ-038 The bench SHALL cover: feed samples 1..8 continuously with m_ready=1 -> one dct_en pulse run, capture at FIRE+DCT_LAT, m_index 0..7 on 8 consecutive cycles, m_last on index 7, blk_cnt=1.
REQ-039 The bench SHALL cover: s_valid toggled at 50% -> lanes 0..7 hold samples in arrival order, with no gaps or duplicates.
REQ-040 The bench SHALL cover: m_ready low for 5 cycles at index 3 -> m_data/m_index held at lane 3, then resuming 4..7 with no loss.
REQ-041 The bench SHALL cover: s_valid held high during WAIT/DRAIN -> s_ready=0 and lane contents unchanged.
REQ-042 The bench SHALL cover: rst asserted at drain index 5 -> next cycle FILL, m_valid=0, blk_cnt=0, and a new block starts at lane 0.
REQ-043 The bench SHALL cover: force blk_cnt to 0xFFFF and complete one block -> blk_cnt=0x0000; DCT_LAT=1 and DCT_LAT=15 runs -> capture timing matches REQ-023.
